dcpu16_mem_slv: RTL

//  Dual-port memory responder for the DCPU16 core. Terminates the F bus (fetch/save) and the G bus (load).

---
 rtl/dcpu16_mem_slv.sv | 82 ++++++++
 1 files changed

// File: rtl/dcpu16_mem_slv.sv
// dcpu16_mem_slv: dual-port F/G bus memory responder over one shared word RAM.
// Define DCPU16_MEM_BYPASS_EN to forward write data to a same-edge, same-address reader.
module dcpu16_mem_slv #(
   parameter int AW   = 10,
   parameter int WAIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] f_adr,
   input  logic [15:0] f_dto,
   input  logic        f_stb,
   input  logic        f_wre,
   output logic [15:0] f_dti,
   output logic        f_ack,
   input  logic [15:0] g_adr,
   input  logic [15:0] g_dto,
   input  logic        g_stb,
   input  logic        g_wre,
   output logic [15:0] g_dti,
   output logic        g_ack
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE, ACK} state_t;
`ifdef DCPU16_MEM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam logic [3:0] CNT0 = 4'(WAIT == 0 ? 0 : WAIT - 1);
   logic [15:0] mem [2**AW];
   state_t st [2];
   logic [3:0] cnt [2];
   logic [AW-1:0] la [2], adr [2];
   logic [15:0] ld [2], rd [2], dto [2], dti [2];
   logic [1:0] stb, wre, lw, ack, wr;
   logic unused;
   assign adr = '{f_adr[AW-1:0], g_adr[AW-1:0]};
   assign dto = '{f_dto, g_dto};
   assign stb = {g_stb, f_stb};
   assign wre = {g_wre, f_wre};
   assign {g_ack, f_ack} = ack;
   assign f_dti = dti[0];
   assign g_dti = dti[1];
   assign unused = ^{1'b0, f_adr[15:AW], g_adr[15:AW]};
   for (genvar p = 0; p < 2; p++) begin : g_port
      assign wr[p] = st[p] == DONE && lw[p];
      assign rd[p] = (BYP && wr[1-p] && la[0] == la[1]) ? ld[1-p] : mem[la[p]];
      always_ff @(posedge clk) begin
         if (rst) begin
            st[p] <= IDLE;
            cnt[p] <= 4'd0;
            ack[p] <= 1'b0;
            dti[p] <= 16'h0000;
         end else begin
            ack[p] <= st[p] == DONE;
            case (st[p])
               IDLE: if (stb[p]) begin
                  la[p] <= adr[p];
                  ld[p] <= dto[p];
                  lw[p] <= wre[p];
                  cnt[p] <= CNT0;
                  st[p] <= WAIT == 0 ? DONE : BUSY;
               end
               BUSY: begin
                  cnt[p] <= cnt[p] - 4'd1;
                  st[p] <= !stb[p] ? IDLE : cnt[p] == 4'd0 ? DONE : BUSY;
               end
               DONE: begin
                  if (!lw[p]) dti[p] <= rd[p];
                  st[p] <= ACK;
               end
               default: st[p] <= IDLE;
            endcase
         end
      end
   end
   // F is written last so it wins a same-address write collision
   always_ff @(posedge clk)
      if (!rst) begin
         if (wr[1]) mem[la[1]] <= ld[1];
         if (wr[0]) mem[la[0]] <= ld[0];
      end
endmodule
